// File: rtl/rx_lane_align_pkg.sv
// Shared types for the RX word-alignment controller: lane state encoding,
// per-lane status bundle and a constant clog2 helper for counter sizing.
package rx_lane_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SLIP  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LOCK  = 3'd4,
        ST_FAIL  = 3'd5
    } lane_state_e;

    typedef struct packed {
        logic bitslip;
        logic lock;
        logic err;
    } lane_stat_t;

    // Never returns less than 1 so every counter has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rx_lane_align_fsm.sv
// One lane's alignment FSM: pattern check, bounded bitslip search with
// post-slip settle time, lock declaration and loss-of-lock monitoring.
module rx_lane_align_fsm
    import rx_lane_align_pkg::*;
#(
    parameter int            W          = 8,
    parameter logic [W-1:0]  PAT        = 8'hA5,
    parameter int            CNT_WAIT_W = 2,
    parameter int            WAIT_MAX   = 0,
    parameter int            TEST       = 4,
    parameter int            LOSS_MAX   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         recal,
    input  logic         train,
    input  logic [W-1:0] word,
    output lane_stat_t   stat
);
    localparam int SLIP_W  = clog2(W + 1);
    localparam int MATCH_W = clog2(TEST + 1);
    localparam int MISS_W  = clog2(LOSS_MAX + 1);

    lane_state_e             state, state_nx;
    logic [SLIP_W-1:0]       slip_cnt, slip_cnt_nx;
    logic [MATCH_W-1:0]      match_cnt, match_cnt_nx;
    logic [MISS_W-1:0]       miss_cnt, miss_cnt_nx;
    logic [CNT_WAIT_W-1:0]   wait_cnt, wait_cnt_nx;
    lane_stat_t              stat_nx;
    logic                    hit;

    assign hit = (word == PAT);

    // State register; status is registered from the next state so every
    // flag changes on the same edge as the transition that causes it.
    always_ff @(posedge clk) begin
        if (rst || recal) begin
            state     <= ST_IDLE;
            slip_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            wait_cnt  <= '0;
            stat      <= '0;
        end else begin
            state     <= state_nx;
            slip_cnt  <= slip_cnt_nx;
            match_cnt <= match_cnt_nx;
            miss_cnt  <= miss_cnt_nx;
            wait_cnt  <= wait_cnt_nx;
            stat      <= stat_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        slip_cnt_nx  = slip_cnt;
        match_cnt_nx = match_cnt;
        miss_cnt_nx  = miss_cnt;
        wait_cnt_nx  = wait_cnt;
        case (state)
            ST_IDLE: begin
                slip_cnt_nx  = '0;
                match_cnt_nx = '0;
                miss_cnt_nx  = '0;
                wait_cnt_nx  = '0;
                state_nx     = ST_CHECK;
            end
            ST_CHECK: begin
                if (hit) begin
                    match_cnt_nx = match_cnt + 1'b1;
                    if (match_cnt == MATCH_W'(TEST - 1)) state_nx = ST_LOCK;
                end else if (slip_cnt < SLIP_W'(W)) begin
                    match_cnt_nx = '0;
                    state_nx     = ST_SLIP;
                end else begin
                    state_nx = ST_FAIL;
                end
            end
            ST_SLIP: begin
                slip_cnt_nx = slip_cnt + 1'b1;
                wait_cnt_nx = '0;
                state_nx    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == CNT_WAIT_W'(WAIT_MAX)) state_nx = ST_CHECK;
                else wait_cnt_nx = wait_cnt + 1'b1;
            end
            ST_LOCK: begin
                if (!train || hit) begin
                    miss_cnt_nx = '0;
                end else if (miss_cnt == MISS_W'(LOSS_MAX - 1)) begin
                    // Lost alignment: restart a full search from scratch.
                    miss_cnt_nx  = '0;
                    slip_cnt_nx  = '0;
                    match_cnt_nx = '0;
                    state_nx     = ST_CHECK;
                end else begin
                    miss_cnt_nx = miss_cnt + 1'b1;
                end
            end
            ST_FAIL: state_nx = ST_FAIL;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        stat_nx         = '0;
        stat_nx.bitslip = (state_nx == ST_SLIP);
        stat_nx.lock    = (state_nx == ST_LOCK);
        stat_nx.err     = (state_nx == ST_FAIL);
    end

endmodule

// File: rtl/rx_lane_align.sv
// Multi-lane RX word-alignment controller: one alignment FSM per lane,
// a registered copy of the lane words and an all-lanes-locked flag.
module rx_lane_align
    import rx_lane_align_pkg::*;
#(
    parameter int            LANES      = 2,
    parameter int            W          = 8,
    parameter logic [W-1:0]  PAT        = 8'hA5,
    parameter int            CNT_WAIT_W = 2,
    parameter int            WAIT_MAX   = 0,
    parameter int            TEST       = 4,
    parameter int            LOSS_MAX   = 4
) (
    input  logic               pclk,
    input  logic               Rs,
    input  logic               recal,
    input  logic               train,
    input  logic [LANES*W-1:0] din,
    output logic [LANES*W-1:0] dout,
    output logic [LANES-1:0]   bitslip,
    output logic [LANES-1:0]   lane_lock,
    output logic [LANES-1:0]   slip_err,
    output logic               cal
);
    logic [LANES-1:0][W-1:0]   din_lane;
    lane_stat_t [LANES-1:0]    stat;

    assign din_lane = din;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        rx_lane_align_fsm #(
            .W          (W),
            .PAT        (PAT),
            .CNT_WAIT_W (CNT_WAIT_W),
            .WAIT_MAX   (WAIT_MAX),
            .TEST       (TEST),
            .LOSS_MAX   (LOSS_MAX)
        ) u_fsm (
            .clk   (pclk),
            .rst   (Rs),
            .recal (recal),
            .train (train),
            .word  (din_lane[i]),
            .stat  (stat[i])
        );

        assign bitslip[i]   = stat[i].bitslip;
        assign lane_lock[i] = stat[i].lock;
        assign slip_err[i]  = stat[i].err;
    end

    // dout is a plain data stage: recal restarts alignment but keeps data flowing.
    always_ff @(posedge pclk) begin
        if (Rs) dout <= '0;
        else    dout <= din;
    end

    always_ff @(posedge pclk) begin
        if (Rs || recal) cal <= 1'b0;
        else             cal <= &lane_lock;
    end

endmodule

// File: tb/tb_rx_lane_align.sv
// Randomized bench for rx_lane_align: deserializer model plus a closed-form
// timeline predictor for slips, lock, failure and the all-locked flag.
module tb_rx_lane_align;
    localparam int           LANES      = 2;
    localparam int           W          = 8;
    localparam logic [W-1:0] PAT        = 8'hA5;
    localparam int           CNT_WAIT_W = 2;
    localparam int           WAIT_MAX   = 0;
    localparam int           TEST       = 4;
    localparam int           LOSS_MAX   = 4;
    localparam int           P          = WAIT_MAX + 3;

    logic               pclk = 1'b0;
    logic               Rs = 1'b1;
    logic               recal = 1'b0;
    logic               train = 1'b0;
    logic [LANES*W-1:0] din = '0;
    logic [LANES*W-1:0] dout;
    logic [LANES-1:0]   bitslip, lane_lock, slip_err;
    logic               cal;

    int                 checks = 0;
    int                 errors = 0;
    logic [W-1:0]       cur [LANES];
    logic [LANES-1:0]   bs_prev = '0;
    logic [LANES*W-1:0] din_last = '0;

    rx_lane_align #(
        .LANES(LANES), .W(W), .PAT(PAT), .CNT_WAIT_W(CNT_WAIT_W),
        .WAIT_MAX(WAIT_MAX), .TEST(TEST), .LOSS_MAX(LOSS_MAX)
    ) dut (
        .pclk(pclk), .Rs(Rs), .recal(recal), .train(train), .din(din),
        .dout(dout), .bitslip(bitslip), .lane_lock(lane_lock),
        .slip_err(slip_err), .cal(cal)
    );

    always #5 pclk = ~pclk;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] w, input int k);
        logic [W-1:0] r;
        r = w;
        for (int i = 0; i < k; i++) r = {r[W-2:0], r[W-1]};
        return r;
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] w, input int k);
        logic [W-1:0] r;
        r = w;
        for (int i = 0; i < k; i++) r = {r[0], r[W-1:1]};
        return r;
    endfunction

    // Left rotations needed to reach PAT; W means the word never aligns.
    function automatic int rot_needed(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) if (rotl(w, k) == PAT) return k;
        return W;
    endfunction

    // One clock: check dout, then apply pending slips and present new words.
    task automatic step();
        logic [LANES*W-1:0] exp_d;
        @(posedge pclk);
        #1;
        exp_d = Rs ? '0 : din_last;
        checks++;
        if (dout !== exp_d) begin
            errors++;
            $display("FAIL dout: got %h want %h", dout, exp_d);
        end
        for (int i = 0; i < LANES; i++) if (bs_prev[i]) cur[i] = rotl(cur[i], 1);
        bs_prev = bitslip;
        for (int i = 0; i < LANES; i++) din[i*W +: W] = cur[i];
        din_last = din;
    endtask

    task automatic restart(input bit use_rs, input string name);
        if (use_rs) Rs = 1'b1;
        else        recal = 1'b1;
        step();
        checks++;
        if ({bitslip, lane_lock, slip_err, cal} !== '0) begin
            errors++;
            $display("FAIL %s: got bs=%b lock=%b err=%b cal=%b want all 0",
                     name, bitslip, lane_lock, slip_err, cal);
        end
        Rs    = 1'b0;
        recal = 1'b0;
    endtask

    // Cycle 1 is the first CHECK cycle. r<0: lane already locked and stays so.
    task automatic align_check(input int r0, input int r1, input bit cal_init,
                               input int ncyc, input string name);
        int               r [LANES];
        logic [LANES-1:0] e_bs, e_lock, e_err, prev_lock;
        logic             e_cal;
        r[0] = r0;
        r[1] = r1;
        prev_lock = '0;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            for (int i = 0; i < LANES; i++) begin
                int ns;
                if (r[i] < 0) begin
                    e_bs[i] = 1'b0; e_lock[i] = 1'b1; e_err[i] = 1'b0;
                end else begin
                    ns        = (r[i] < W) ? r[i] : W;
                    e_bs[i]   = (c >= 2) && ((c - 2) % P == 0) && ((c - 2) / P < ns);
                    e_lock[i] = (r[i] < W) && (c >= 1 + P * r[i] + TEST);
                    e_err[i]  = (r[i] >= W) && (c >= 2 + P * W);
                end
            end
            e_cal = (c == 1) ? cal_init : &prev_lock;
            checks++;
            if ({bitslip, lane_lock, slip_err, cal} !== {e_bs, e_lock, e_err, e_cal}) begin
                errors++;
                $display("FAIL %s cyc=%0d: got bs=%b lock=%b err=%b cal=%b want bs=%b lock=%b err=%b cal=%b",
                         name, c, bitslip, lane_lock, slip_err, cal, e_bs, e_lock, e_err, e_cal);
            end
            prev_lock = e_lock;
        end
    endtask

    task automatic test_reset();
        cur[0] = W'($urandom);
        cur[1] = W'($urandom);
        restart(1'b1, "reset");
    endtask

    task automatic test_align_fixed();
        cur[0] = PAT;
        cur[1] = rotr(PAT, 3);
        restart(1'b1, "align_fixed_rst");
        align_check(0, 3, 1'b0, 20, "align_fixed");
    endtask

    task automatic test_loss_of_lock();
        int k;
        train = 1'b1;
        for (int j = 0; j < 8; j++) begin
            cur[0] = (j == 3) ? PAT : PAT ^ W'($urandom_range(1, (1 << W) - 1));
            step();
            checks++;
            if (lane_lock !== 2'b11 || cal !== 1'b1) begin
                errors++;
                $display("FAIL loss_hold j=%0d: got lock=%b cal=%b want lock=11 cal=1",
                         j, lane_lock, cal);
            end
        end
        k = $urandom_range(1, W - 1);
        cur[0] = rotr(PAT, k);
        align_check(rot_needed(cur[0]), -1, 1'b1, 1 + P * k + TEST + 3, "loss_relock");
    endtask

    task automatic test_train_off();
        train = 1'b0;
        for (int j = 0; j < 30; j++) begin
            cur[0] = W'($urandom);
            cur[1] = W'($urandom);
            step();
            checks++;
            if (lane_lock !== 2'b11 || bitslip !== 2'b00 || slip_err !== 2'b00 || cal !== 1'b1) begin
                errors++;
                $display("FAIL train_off j=%0d: got lock=%b bs=%b err=%b cal=%b want lock=11 bs=00 err=00 cal=1",
                         j, lane_lock, bitslip, slip_err, cal);
            end
        end
    endtask

    task automatic test_reset_locked();
        restart(1'b1, "reset_locked");
    endtask

    task automatic test_align_random();
        int r0, r1, m;
        for (int n = 0; n < 4; n++) begin
            cur[0] = rotr(PAT, $urandom_range(0, W - 1));
            cur[1] = rotr(PAT, $urandom_range(0, W - 1));
            restart(1'b1, "align_rand_rst");
            r0 = rot_needed(cur[0]);
            r1 = rot_needed(cur[1]);
            m  = (r0 > r1) ? r0 : r1;
            align_check(r0, r1, 1'b0, 1 + P * m + TEST + 3, "align_rand");
        end
    endtask

    task automatic test_fail();
        cur[0] = PAT;
        cur[1] = '0;
        restart(1'b1, "fail_rst");
        align_check(0, W, 1'b0, 2 + P * W + 4, "fail");
        restart(1'b0, "fail_recal");
        align_check(rot_needed(cur[0]), rot_needed(cur[1]), 1'b0, 6, "fail_after_recal");
    endtask

    task automatic test_recal_wait();
        cur[0] = PAT;
        cur[1] = rotr(PAT, 3);
        restart(1'b1, "recal_wait_rst");
        align_check(0, 3, 1'b0, 3, "recal_wait_pre");
        restart(1'b0, "recal_wait");
        align_check(rot_needed(cur[0]), rot_needed(cur[1]), 1'b0,
                    1 + P * rot_needed(cur[1]) + TEST + 3, "recal_wait_relock");
    endtask

    initial begin
        cur[0] = '0;
        cur[1] = '0;
        test_reset();
        test_align_fixed();
        test_loss_of_lock();
        test_train_off();
        test_reset_locked();
        test_align_random();
        test_fail();
        test_recal_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
